// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and sizes for the truth-table sequencer: the FSM state
// encoding and the vector/table geometry of a 3-input logic function.
package truth_table_sequencer_pkg;

   localparam int NUM_VECTORS = 8;
   localparam int VEC_W       = 3;
   localparam int TABLE_W     = 8;
   localparam int CNT_W       = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Settle countdown: load captures a start value, then the count falls by
// one per cycle and parks at zero; zero flags the end of the settle window.
module settle_timer
   import truth_table_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps a 3-input combinational function through inputs 000..111, waits
// SETTLE_CYCLES per vector, and assembles the 8-bit truth table (MSB = 000).
module truth_table_sequencer
   import truth_table_sequencer_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [TABLE_W-1:0] expected,
   output logic [VEC_W-1:0]   dut_in,
   input  logic               dut_out,
   output logic               busy,
   output logic               done,
   output logic [TABLE_W-1:0] table_out,
   output logic               match,
   output state_t             dbg_state
);

   localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VECTORS - 1);
   localparam logic [VEC_W-1:0] MSB_IDX  = VEC_W'(TABLE_W - 1);

   state_t             state, state_n;
   logic [VEC_W-1:0]   idx, idx_n;
   logic [TABLE_W-1:0] exp_q, exp_n;
   logic [TABLE_W-1:0] table_n;
   logic               match_n, busy_n, done_n;
   logic               load, zero;

   settle_timer u_settle_timer (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .value (RELOAD),
      .zero  (zero)
   );

   // Handshake: start is accepted only on an IDLE edge; busy rises on that
   // edge and falls on the edge entering DONE, where done pulses for one cycle.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      exp_n   = exp_q;
      table_n = table_out;
      match_n = match;
      busy_n  = busy;
      done_n  = 1'b0;
      load    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               idx_n   = '0;
               table_n = '0;
               match_n = 1'b0;
               exp_n   = expected;
               busy_n  = 1'b1;
               load    = 1'b1;
               state_n = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (zero) state_n = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            table_n[MSB_IDX - idx] = dut_out;
            if (idx == LAST_IDX) begin
               // Match is resolved with the final bit so it is valid alongside done.
               match_n = (table_n == exp_q);
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = ST_DONE;
            end else begin
               idx_n   = idx + 1'b1;
               load    = 1'b1;
               state_n = ST_SETTLE;
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         idx       <= '0;
         exp_q     <= '0;
         table_out <= '0;
         match     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         exp_q     <= exp_n;
         table_out <= table_n;
         match     <= match_n;
         busy      <= busy_n;
         done      <= done_n;
      end
   end

   assign dut_in    = idx;
   assign dbg_state = state;

endmodule
